// File: rtl/count_ctrl_if.sv
// Bus between the CPU-side I/O decode and the interval timer controller.
// The master drives configuration, run control and acknowledge; the slave returns counter status.
interface count_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_mode;
  logic             start;
  logic             stop;
  logic             irq_ack;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             irq;
  logic             ovf;
  logic             busy;

  modport master (
    output cfg_we, cfg_period, cfg_mode, start, stop, irq_ack,
    input  cnt, tick, irq, ovf, busy
  );

  modport slave (
    input  cfg_we, cfg_period, cfg_mode, start, stop, irq_ack,
    output cnt, tick, irq, ovf, busy
  );
endinterface

// File: rtl/count_ctrl.sv
// Programmable interval timer: sequences a cycle counter through IDLE/RUN,
// emits a one-cycle tick at each terminal count and keeps a level irq with a sticky overrun flag.
module count_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  count_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] period_r;
  logic             mode_r;
  logic [WIDTH-1:0] start_period;
  logic [WIDTH-1:0] last_cnt;

  // A write in the same cycle as start must already govern that start.
  assign start_period = bus.cfg_we ? bus.cfg_period : period_r;
  assign last_cnt     = period_r - {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period_r   <= '0;
      mode_r     <= 1'b0;
      bus.cnt    <= '0;
      bus.tick   <= 1'b0;
      bus.irq    <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      bus.tick <= 1'b0;
      if (bus.irq_ack) begin
        bus.irq <= 1'b0;
        bus.ovf <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            period_r <= bus.cfg_period;
            mode_r   <= bus.cfg_mode;
          end
          if (bus.start && !bus.stop && (start_period != '0)) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            bus.cnt  <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.cnt  <= '0;
          end else if (bus.cnt == last_cnt) begin
            bus.cnt  <= '0;
            bus.tick <= 1'b1;
            // A terminal event on the acknowledge edge re-raises irq but is not an overrun.
            bus.irq  <= 1'b1;
            if (bus.irq && !bus.irq_ack) begin
              bus.ovf <= 1'b1;
            end
            if (!mode_r) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            bus.cnt <= bus.cnt + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
      endcase
    end
  end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Programmable interval-timer controller wrapping the free-running cycle counter. It holds a software-written period and mode, sequences the counter through idle/run, emits a one-cycle tick at each terminal count, and raises a level interrupt with an acknowledge handshake toward the CPU. It sits between the CPU's memory-mapped I/O decode and the interrupt input.

Parameters:
WIDTH, 8, counter and period width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
cfg_we  input  1  write-enable for period/mode registers
cfg_period  input  WIDTH  terminal period in cycles; 0 = invalid
cfg_mode  input  1  0 = one-shot, 1 = periodic
start  input  1  request to begin counting
stop  input  1  request to abort counting
irq_ack  input  1  CPU acknowledge, clears irq and ovf
cnt  output  WIDTH  current count value (registered)
tick  output  1  one-cycle pulse at terminal count (registered)
irq  output  1  level interrupt, held until acknowledged
ovf  output  1  sticky: terminal count occurred while irq already set
busy  output  1  high while in RUN

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- Reset: state=IDLE, cnt=0, period_r=0, mode_r=0, tick=0, irq=0, ovf=0, busy=0. Reset mid-RUN aborts immediately; no tick or irq on that edge.
- States: IDLE, RUN. busy = (state==RUN), registered with state.
- cfg_we: captures cfg_period/cfg_mode only in IDLE; ignored in RUN. cfg_we and start in the same IDLE cycle: start uses the newly written values.
- IDLE -> RUN: start=1, stop=0, effective period != 0. On that edge cnt<=0, busy<=1. start with period 0 is ignored (remain IDLE).
- RUN, per edge, priority order:
  1. stop=1: -> IDLE, cnt<=0, no tick and no irq, even if this is the terminal cycle.
  2. cnt==period_r-1: cnt<=0, tick<=1, irq<=1. If irq was already 1 (and not acked this cycle), ovf<=1. Periodic: stay RUN. One-shot: -> IDLE, busy<=0.
  3. Otherwise cnt<=cnt+1, tick<=0.
- start while in RUN: ignored (no restart).
- tick is high for exactly one cycle, coinciding with cnt==0 after a wrap. Period p yields a tick every p cycles. Period 1 in periodic mode gives tick high every cycle and cnt held at 0.
- irq_ack: clears irq and ovf on the next edge. A terminal event on the same edge wins: irq stays 1, and ovf is not set by that event.
- Arithmetic: cnt is unsigned WIDTH-bit. Period 2^WIDTH-1 is the maximum, and the comparison uses period_r-1, so no overflow is possible.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst 3 cycles mid-RUN (period 5) -> next cycle cnt=0, busy=0, irq=0, tick=0, ovf=0.
- Periodic: write period 4, mode 1; start at edge E0 -> cnt 0,1,2,3,0,... after E0..E4. tick=1 and irq=1 after E4, tick again after E8 and E12, with tick=0 between.
- One-shot: period 3, mode 0; start at E0 -> tick and irq after E3, busy=0 after E3, cnt stays 0. A further start at E5 re-arms, giving a tick after E8.
- Overrun/ack: periodic period 2, never ack -> ovf=1 after the second tick. Pulse irq_ack -> irq=0 and ovf=0 next cycle. irq_ack coinciding with a tick edge -> irq remains 1.
- Stop priority: periodic period 4; assert stop in the cycle where cnt=3 -> no tick, state IDLE, cnt=0, busy=0, irq unchanged.
- Config guards: start with period 0 -> busy stays 0. cfg_we with period 7 during RUN (period 4) -> ticks remain every 4 cycles, and the stored period stays 4 after a subsequent stop/start.
